// File: rtl/bitonic_sort_pipe_pkg.sv
// Shared types and compile-time helpers for the pipelined bitonic sorter.
package sort_pkg;

   localparam int MAX_LOG2N = 5;

   // Key layout {data, idx} for the default configuration (WIDTH 8, LOG2N 3).
   // Modules with other parameters build the same layout at their own widths.
   typedef struct packed {
      logic [7:0] data;
      logic [2:0] idx;
   } key_t;

   // Partner lane of a compare-exchange and whether the pair sorts upward.
   typedef struct packed {
      logic [4:0] lane;
      logic       up;
   } partner_t;

   function automatic int num_stages(input int log2n);
      return log2n * (log2n + 1) / 2;
   endfunction

   // Columns are grouped by merge size p; group p holds p+1 columns with
   // distance q running from p down to 0. The grouping does not depend on N.
   function automatic partner_t partner(input int stage, input int lane);
      partner_t r;
      int s;
      int p;
      int q;
      s = stage;
      p = 0;
      for (int k = 0; k < MAX_LOG2N; k++) begin
         if (s > p) begin
            s = s - p - 1;
            p = p + 1;
         end
      end
      q      = p - s;
      r.lane = 5'(lane ^ (1 << q));
      r.up   = (((lane >> (p + 1)) & 1) == 0);
      return r;
   endfunction

endpackage

// File: rtl/bitonic_sort_pipe_cmp_swap.sv
// Combinational compare-exchange on {data, idx} keys. lo feeds the lower lane,
// hi the upper lane; with dir_up = 0 the larger key goes to lo.
module cmp_swap #(
   parameter int WIDTH  = 8,
   parameter int IW     = 3,
   parameter int SIGNED = 0
) (
   input  logic [WIDTH+IW-1:0] a,
   input  logic [WIDTH+IW-1:0] b,
   input  logic                dir_up,
   output logic [WIDTH+IW-1:0] lo,
   output logic [WIDTH+IW-1:0] hi
);

   localparam int KW = WIDTH + IW;

   logic [KW-1:0] ka;
   logic [KW-1:0] kb;
   logic          a_lt_b;

   // Flipping the data sign bit turns a two's complement compare into an unsigned one.
   always_comb begin
      ka = a;
      kb = b;
      if (SIGNED != 0) begin
         ka[KW-1] = ~a[KW-1];
         kb[KW-1] = ~b[KW-1];
      end
      a_lt_b = (ka < kb);
      lo     = (a_lt_b == dir_up) ? a : b;
      hi     = (a_lt_b == dir_up) ? b : a;
   end

endmodule

// File: rtl/bitonic_sort_pipe.sv
// Fully pipelined bitonic sorter with per-vector direction and global-stall
// valid/ready flow control. The network always sorts ascending; descending
// vectors are reversed at the output.
module bitonic_sort_pipe
   import sort_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int LOG2N  = 3,
   parameter int SIGNED = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_desc,
   input  logic [WIDTH-1:0] in_data  [0:(1<<LOG2N)-1],
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data [0:(1<<LOG2N)-1],
   output logic [LOG2N-1:0] out_idx  [0:(1<<LOG2N)-1]
);

   localparam int N  = 1 << LOG2N;
   localparam int NS = num_stages(LOG2N);
   localparam int KW = WIDTH + LOG2N;

   logic [KW-1:0] key_in [0:N-1];
   logic [KW-1:0] col_d  [0:NS-1][0:N-1];
   logic [KW-1:0] col_q  [0:NS-1][0:N-1];
   logic [NS-1:0] vld_q;
   logic [NS-1:0] desc_q;
   logic          adv;

   assign out_valid = vld_q[NS-1];
   assign adv       = out_ready | ~out_valid;
   assign in_ready  = adv;

   for (genvar l = 0; l < N; l++) begin : g_key
      assign key_in[l] = {in_data[l], LOG2N'(l)};
   end

   for (genvar s = 0; s < NS; s++) begin : g_col
      logic [KW-1:0] src [0:N-1];
      for (genvar l = 0; l < N; l++) begin : g_src
         if (s == 0) begin : g_first
            assign src[l] = key_in[l];
         end else begin : g_next
            assign src[l] = col_q[s-1][l];
         end
      end
      for (genvar l = 0; l < N; l++) begin : g_lane
         localparam logic [5:0] P  = partner(s, l);
         localparam int         PL = int'(P[5:1]);
         localparam bit         PU = P[0];
         if (PL > l) begin : g_cs
            cmp_swap #(
               .WIDTH  (WIDTH),
               .IW     (LOG2N),
               .SIGNED (SIGNED)
            ) u_cs (
               .a      (src[l]),
               .b      (src[PL]),
               .dir_up (PU),
               .lo     (col_d[s][l]),
               .hi     (col_d[s][PL])
            );
         end
      end
   end

   // Advance all stages together; flush clears valid bits and leaves data untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q  <= '0;
         desc_q <= '0;
         for (int s = 0; s < NS; s++) begin
            for (int l = 0; l < N; l++) begin
               col_q[s][l] <= '0;
            end
         end
      end else if (flush) begin
         vld_q <= '0;
      end else if (adv) begin
         vld_q[0]  <= in_valid;
         desc_q[0] <= in_desc;
         for (int s = 1; s < NS; s++) begin
            vld_q[s]  <= vld_q[s-1];
            desc_q[s] <= desc_q[s-1];
         end
         for (int s = 0; s < NS; s++) begin
            for (int l = 0; l < N; l++) begin
               col_q[s][l] <= col_d[s][l];
            end
         end
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_out
      assign out_data[k] = desc_q[NS-1] ? col_q[NS-1][N-1-k][KW-1:LOG2N]
                                        : col_q[NS-1][k][KW-1:LOG2N];
      assign out_idx[k]  = desc_q[NS-1] ? col_q[NS-1][N-1-k][LOG2N-1:0]
                                        : col_q[NS-1][k][LOG2N-1:0];
   end

endmodule

// File: tb/tb_bitonic_sort_pipe.sv
// Scoreboard bench for bitonic_sort_pipe over several parameter sets.
module tb_bitonic_sort_pipe;

   typedef struct packed {
      logic [31:0][7:0] d;
      logic [31:0][4:0] i;
   } exp_t;

   localparam int NCFG = 5;

   logic clk;
   int   total;
   int   bad;
   bit   done_v [0:NCFG-1];

   initial begin
      clk   = 1'b0;
      total = 0;
      bad   = 0;
      for (int g = 0; g < NCFG; g++) done_v[g] = 1'b0;
   end

   always #5 clk = ~clk;

   function automatic int cfg_l(input int g);
      case (g)
         0: return 3;
         1: return 1;
         2: return 2;
         3: return 5;
         default: return 3;
      endcase
   endfunction

   function automatic int cfg_s(input int g);
      return (g == 4) ? 1 : 0;
   endfunction

   function automatic logic [31:0][7:0] v8(input int a0, a1, a2, a3, a4, a5, a6, a7);
      logic [31:0][7:0] r;
      r = '0;
      r[0] = 8'(a0); r[1] = 8'(a1); r[2] = 8'(a2); r[3] = 8'(a3);
      r[4] = 8'(a4); r[5] = 8'(a5); r[6] = 8'(a6); r[7] = 8'(a7);
      return r;
   endfunction

   function automatic logic [31:0][4:0] i8(input int a0, a1, a2, a3, a4, a5, a6, a7);
      logic [31:0][4:0] r;
      r = '0;
      r[0] = 5'(a0); r[1] = 5'(a1); r[2] = 5'(a2); r[3] = 5'(a3);
      r[4] = 5'(a4); r[5] = 5'(a5); r[6] = 5'(a6); r[7] = 5'(a7);
      return r;
   endfunction

   // Reference: insertion sort on (value, lane), then optional reversal.
   function automatic exp_t model(input logic [31:0][7:0] d, input int n, input bit sgn,
                                  input logic dsc);
      exp_t r;
      int   key [32];
      int   t;
      int   v;
      int   src;
      int   id;
      r = '0;
      for (int i = 0; i < n; i++) begin
         v      = sgn ? (int'(d[i]) ^ 128) : int'(d[i]);
         key[i] = v * 32 + i;
      end
      for (int i = 1; i < n; i++) begin
         for (int j = i; j > 0; j--) begin
            if (key[j-1] > key[j]) begin
               t        = key[j];
               key[j]   = key[j-1];
               key[j-1] = t;
            end
         end
      end
      for (int k = 0; k < n; k++) begin
         src    = dsc ? key[n-1-k] : key[k];
         id     = src % 32;
         r.d[k] = d[id];
         r.i[k] = 5'(id);
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, expv);
      end
   endtask

   for (genvar g = 0; g < NCFG; g++) begin : g_cfg
      localparam int L  = cfg_l(g);
      localparam int N  = 1 << L;
      localparam int NS = L * (L + 1) / 2;
      localparam int S  = cfg_s(g);

      logic         rst;
      logic         flush;
      logic         in_valid;
      logic         in_ready;
      logic         in_desc;
      logic         out_valid;
      logic         out_ready;
      logic [7:0]   in_data  [0:N-1];
      logic [7:0]   out_data [0:N-1];
      logic [L-1:0] out_idx  [0:N-1];
      exp_t         q [$];
      bit           rnd_ready;

      bitonic_sort_pipe #(
         .WIDTH  (8),
         .LOG2N  (L),
         .SIGNED (S)
      ) dut (
         .clk       (clk),
         .rst       (rst),
         .flush     (flush),
         .in_valid  (in_valid),
         .in_ready  (in_ready),
         .in_desc   (in_desc),
         .in_data   (in_data),
         .out_valid (out_valid),
         .out_ready (out_ready),
         .out_data  (out_data),
         .out_idx   (out_idx)
      );

      task automatic get_out(output logic [31:0][7:0] ad, output logic [31:0][4:0] ai);
         ad = '0;
         ai = '0;
         for (int k = 0; k < N; k++) begin
            ad[k] = out_data[k];
            ai[k] = 5'(out_idx[k]);
         end
      endtask

      // Called at posedge+1; returns at posedge+1 after the accepting edge.
      task automatic drive(input logic [31:0][7:0] d, input logic dsc, input exp_t e);
         int w;
         w        = 0;
         in_valid = 1'b1;
         in_desc  = dsc;
         for (int k = 0; k < N; k++) in_data[k] = d[k];
         @(negedge clk);
         while (!in_ready && w < 500) begin
            @(negedge clk);
            w++;
         end
         chk($sformatf("cfg%0d accept", g), 256'(in_ready), 256'(1));
         if (in_ready && !flush) q.push_back(e);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      endtask

      task automatic send_lat(input logic [31:0][7:0] d, input logic dsc, input exp_t e);
         int lat;
         drive(d, dsc, e);
         lat = 1;
         for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            lat++;
         end
         chk($sformatf("cfg%0d latency", g), 256'(lat), 256'(NS));
         @(posedge clk);
         #1;
      endtask

      task automatic send_rand(input logic dsc, input bit with_lat);
         logic [31:0][7:0] d;
         exp_t             e;
         int               mode;
         mode = $urandom_range(0, 1);
         for (int k = 0; k < 32; k++)
            d[k] = mode ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
         e = model(d, N, S != 0, dsc);
         if (with_lat) send_lat(d, dsc, e);
         else          drive(d, dsc, e);
      endtask

      task automatic drain();
         for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (q.size() == 0) break;
         end
         chk($sformatf("cfg%0d drained", g), 256'(q.size()), 256'(0));
         @(posedge clk);
         #1;
      endtask

      task automatic init_sig();
         rst       = 1'b1;
         flush     = 1'b0;
         in_valid  = 1'b0;
         in_desc   = 1'b0;
         out_ready = 1'b1;
         rnd_ready = 1'b0;
         for (int k = 0; k < N; k++) in_data[k] = 8'd0;
      endtask

      // Random consumer backpressure while enabled.
      initial begin : rdy
         forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = ($urandom_range(0, 2) != 0);
         end
      end

      // Monitor: pop and compare on every output handshake, check hold during stalls.
      initial begin : mon
         logic             held;
         logic [31:0][7:0] hd;
         logic [31:0][7:0] ad;
         logic [31:0][4:0] hi;
         logic [31:0][4:0] ai;
         exp_t             e;
         held = 1'b0;
         hd   = '0;
         hi   = '0;
         forever begin
            @(negedge clk);
            if (rst) begin
               held = 1'b0;
            end else begin
               get_out(ad, ai);
               if (held) begin
                  chk($sformatf("cfg%0d stall valid", g), 256'(out_valid), 256'(1));
                  chk($sformatf("cfg%0d stall data", g), 256'(ad), 256'(hd));
                  chk($sformatf("cfg%0d stall idx", g), 256'(ai), 256'(hi));
               end
               if (out_valid && out_ready) begin
                  chk($sformatf("cfg%0d output expected", g), 256'(q.size() > 0), 256'(1));
                  if (q.size() > 0) begin
                     e = q.pop_front();
                     chk($sformatf("cfg%0d out_data", g), 256'(ad), 256'(e.d));
                     chk($sformatf("cfg%0d out_idx", g), 256'(ai), 256'(e.i));
                  end
               end
               held = out_valid && !out_ready;
               hd   = ad;
               hi   = ai;
            end
         end
      end

      if (g == 0) begin : g_main
         initial begin
            exp_t             e;
            logic [31:0][7:0] ad;
            logic [31:0][4:0] ai;
            int               cnt;
            init_sig();
            @(negedge clk);
            get_out(ad, ai);
            chk("reset out_valid", 256'(out_valid), 256'(0));
            chk("reset in_ready", 256'(in_ready), 256'(1));
            chk("reset out_data", 256'(ad), 256'(0));
            chk("reset out_idx", 256'(ai), 256'(0));
            @(posedge clk);
            #1;
            rst = 1'b0;

            e.d = v8(0, 1, 2, 3, 4, 5, 6, 7);
            e.i = i8(4, 3, 6, 1, 7, 0, 5, 2);
            send_lat(v8(5, 3, 7, 1, 0, 6, 2, 4), 1'b0, e);

            e.d = v8(9, 9, 9, 9, 1, 1, 0, 0);
            e.i = i8(7, 3, 1, 0, 4, 2, 6, 5);
            drive(v8(9, 9, 1, 9, 1, 0, 0, 9), 1'b1, e);
            drain();

            // Flush with four vectors in flight and one offered on the flush cycle.
            for (int i = 0; i < 4; i++) send_rand(1'(i % 2), 1'b0);
            flush = 1'b1;
            q.delete();
            drive(v8(1, 2, 3, 4, 5, 6, 7, 8), 1'b0, e);
            flush = 1'b0;
            cnt   = 0;
            repeat (10) begin
               @(negedge clk);
               if (out_valid) cnt++;
            end
            chk("flush quiet", 256'(cnt), 256'(0));
            @(posedge clk);
            #1;
            send_rand(1'b0, 1'b0);
            drain();

            // Fill against a stalled consumer, then reset asynchronously.
            out_ready = 1'b0;
            for (int i = 0; i < 6; i++) send_rand(1'(i % 2), 1'b0);
            @(negedge clk);
            chk("stall in_ready", 256'(in_ready), 256'(0));
            chk("stall out_valid", 256'(out_valid), 256'(1));
            repeat (3) @(negedge clk);
            #2;
            rst = 1'b1;
            q.delete();
            #1;
            get_out(ad, ai);
            chk("async rst out_valid", 256'(out_valid), 256'(0));
            chk("async rst in_ready", 256'(in_ready), 256'(1));
            chk("async rst out_data", 256'(ad), 256'(0));
            chk("async rst out_idx", 256'(ai), 256'(0));
            @(negedge clk);
            @(posedge clk);
            #1;
            rst       = 1'b0;
            out_ready = 1'b1;
            cnt       = 0;
            repeat (8) begin
               @(negedge clk);
               if (out_valid) cnt++;
            end
            chk("post rst quiet", 256'(cnt), 256'(0));
            @(posedge clk);
            #1;

            rnd_ready = 1'b1;
            for (int i = 0; i < 20; i++) send_rand(1'(i % 2), 1'b0);
            drain();
            rnd_ready = 1'b0;
            done_v[g] = 1'b1;
         end
      end else if (g == 4) begin : g_sgn
         initial begin
            exp_t e;
            init_sig();
            @(negedge clk);
            @(posedge clk);
            #1;
            rst = 1'b0;
            e.d = v8(8'h80, 8'h81, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h10, 8'h7F);
            e.i = i8(0, 6, 5, 3, 2, 4, 7, 1);
            send_lat(v8(8'h80, 8'h7F, 8'h00, 8'hFF, 8'h01, 8'hFE, 8'h81, 8'h10), 1'b0, e);
            rnd_ready = 1'b1;
            for (int i = 0; i < 30; i++) send_rand(1'($urandom_range(0, 1)), 1'b0);
            drain();
            rnd_ready = 1'b0;
            done_v[g] = 1'b1;
         end
      end else begin : g_sweep
         initial begin
            init_sig();
            @(negedge clk);
            @(posedge clk);
            #1;
            rst = 1'b0;
            send_rand(1'b0, 1'b1);
            rnd_ready = 1'b1;
            for (int i = 0; i < 100; i++) send_rand(1'($urandom_range(0, 1)), 1'b0);
            drain();
            rnd_ready = 1'b0;
            done_v[g] = 1'b1;
         end
      end
   end

   function automatic bit all_done();
      for (int g = 0; g < NCFG; g++) if (!done_v[g]) return 1'b0;
      return 1'b1;
   endfunction

   initial begin
      int c;
      c = 0;
      @(posedge clk);
      while (!all_done() && c < 40000) begin
         @(posedge clk);
         c++;
      end
      total++;
      if (!all_done()) begin
         bad++;
         $display("FAIL run timeout: got %0d cycles want completion", c);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
